io_bus_master: RTL and testbench

- Initiator side of the I/O memory bus: accepts single-word read/write commands from the core over a valid/ready handshake.
- Drives the chip-select/read/write strobes, address and write data to the I/O memory, captures read data and returns a one-cycle response.
- Also owns the interrupt handshake toward the I/O memory: reports a pending interrupt to the core and drives int_ack when the core services it.

---
 rtl/io_bus_master.sv | 166 ++++++++++++++++
 tb/tb_io_bus_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_master.sv
// io_bus_master: initiator for the I/O memory bus.
// Single-word read/write commands, error response, interrupt acknowledge.
module io_bus_master #(
  parameter int ADDR_LIMIT  = 4096,
  parameter int READ_CYCLES = 1,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dm_cs,
  output logic        dm_wr,
  output logic        dm_rd,
  output logic [31:0] Addr,
  output logic [31:0] D_Out,
  input  logic [31:0] D_In,
  input  logic        intr,
  output logic        int_ack,
  output logic        int_pending,
  input  logic        int_service
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_RESP, S_ACK
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [3:0]  r_cnt;
  logic [7:0]  r_tmo;
  logic        r_svc;

  logic        w_accept;
  logic        w_inrange;
  logic [32:0] w_end;
  logic        w_svc_nxt;

  logic        w_cmd_ready;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_err;
  logic        w_cs;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_addr;
  logic [31:0] w_dout;
  logic        w_int_ack;

  // cmd_ready is only ever 1 in IDLE with no service request latched
  assign w_accept  = cmd_valid & cmd_ready;
  // 33-bit sum so that a wrap past 2^32 is caught as out of range
  assign w_end     = {1'b0, cmd_addr} + 33'd3;
  assign w_inrange = w_end < 33'(ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      dm_cs       <= 1'b0;
      dm_wr       <= 1'b0;
      dm_rd       <= 1'b0;
      Addr        <= '0;
      D_Out       <= '0;
      int_ack     <= 1'b0;
      int_pending <= 1'b0;
    end else begin
      r_state     <= w_next;
      cmd_ready   <= w_cmd_ready;
      rsp_valid   <= w_rsp_valid;
      rsp_rdata   <= w_rsp_rdata;
      rsp_err     <= w_rsp_err;
      dm_cs       <= w_cs;
      dm_wr       <= w_wr;
      dm_rd       <= w_rd;
      Addr        <= w_addr;
      D_Out       <= w_dout;
      int_ack     <= w_int_ack;
      int_pending <= intr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_tmo  <= '0;
      r_svc  <= 1'b0;
    end else begin
      r_svc <= w_svc_nxt;
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_cnt  <= 4'(READ_CYCLES);
      end else if (r_state == S_READ) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state != S_ACK) begin
        r_tmo <= 8'(ACK_TIMEOUT);
      end else begin
        r_tmo <= r_tmo - 8'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_svc)
          w_next = S_ACK;
        else if (w_accept)
          w_next = !w_inrange ? S_RESP :
                   cmd_wr     ? S_WRITE : S_READ;
        else if (int_service)
          w_next = S_ACK;
      end
      S_WRITE: w_next = S_RESP;
      S_READ:  w_next = (r_cnt == 4'd1) ? S_RESP : S_READ;
      S_RESP:  w_next = S_IDLE;
      S_ACK: begin
        if (!intr || r_tmo == 8'd1)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Service requests are ignored while the acknowledge is in progress
  always_comb begin
    w_svc_nxt = r_svc;
    if (r_state == S_ACK) begin
      if (w_next == S_IDLE)
        w_svc_nxt = 1'b0;
    end else if (int_service) begin
      w_svc_nxt = 1'b1;
    end
  end

  always_comb begin
    w_cmd_ready = (w_next == S_IDLE) && !w_svc_nxt;
    w_cs        = (w_next == S_WRITE) || (w_next == S_READ);
    w_wr        = (w_next == S_WRITE);
    w_rd        = (w_next == S_READ);
    w_addr      = '0;
    if (w_cs)
      w_addr = (r_state == S_IDLE) ? cmd_addr : r_addr;
    w_dout      = w_wr ? cmd_wdata : 32'h0;
    w_rsp_valid = (w_next == S_RESP);
    w_rsp_err   = (w_next == S_RESP) && (r_state == S_IDLE);
    w_rsp_rdata = '0;
    if (w_next == S_RESP && r_state == S_READ)
      w_rsp_rdata = D_In;
    w_int_ack   = (w_next == S_ACK);
  end

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: directed bench for io_bus_master.
// Instance a uses READ_CYCLES=1, instance b uses READ_CYCLES=3.
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        intr;
  logic        int_service;

  logic        cmd_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a, addr_a, dout_a, din_a;
  logic        cs_a, wr_a, rd_a, int_ack_a, int_pend_a;

  logic        cmd_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b, addr_b, dout_b, din_b;
  logic        cs_b, wr_b, rd_b, int_ack_b, int_pend_b;

  logic [31:0] m_addr, m_data;
  logic        m_ok;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  io_bus_master #(.READ_CYCLES(1)) u_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .rsp_err(rsp_err_a),
    .dm_cs(cs_a), .dm_wr(wr_a), .dm_rd(rd_a),
    .Addr(addr_a), .D_Out(dout_a), .D_In(din_a),
    .intr(intr), .int_ack(int_ack_a),
    .int_pending(int_pend_a), .int_service(int_service)
  );

  io_bus_master #(.READ_CYCLES(3)) u_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b),
    .dm_cs(cs_b), .dm_wr(wr_b), .dm_rd(rd_b),
    .Addr(addr_b), .D_Out(dout_b), .D_In(din_b),
    .intr(intr), .int_ack(int_ack_b),
    .int_pending(int_pend_b), .int_service(int_service)
  );

  // one-word memory behind instance a; fixed preset behind b
  always @(posedge clk)
    if (cs_a && wr_a) begin
      m_addr <= addr_a;
      m_data <= dout_a;
      m_ok   <= 1'b1;
    end

  assign din_a = (m_ok && addr_a == m_addr) ? m_data : 32'h0;
  assign din_b = (addr_b == 32'h200) ? 32'h01020304 : 32'h0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic wr,
                     input logic [31:0] a,
                     input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  int n_rd, rsp_at, n_ack, n_rsp;
  logic [31:0] rdat;

  initial begin
    m_ok = 1'b0; m_addr = '0; m_data = '0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    intr = 1'b0; int_service = 1'b0;
    tick; tick;
    chk("rst_ready", {31'd0, cmd_ready_a}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid_a}, 32'd0);
    chk("rst_cs", {31'd0, cs_a}, 32'd0);
    chk("rst_ack", {31'd0, int_ack_a}, 32'd0);
    reset = 1'b0;
    tick;
    chk("idle_ready", {31'd0, cmd_ready_a}, 32'd1);

    // write 0x100
    cmd(1'b1, 32'h100, 32'hDEADBEEF);
    tick;
    cmd_valid = 1'b0;
    chk("wr_cs", {31'd0, cs_a}, 32'd1);
    chk("wr_wr", {31'd0, wr_a}, 32'd1);
    chk("wr_rd", {31'd0, rd_a}, 32'd0);
    chk("wr_addr", addr_a, 32'h100);
    chk("wr_dout", dout_a, 32'hDEADBEEF);
    chk("wr_busy", {31'd0, cmd_ready_a}, 32'd0);
    tick;
    chk("wr_rsp", {31'd0, rsp_valid_a}, 32'd1);
    chk("wr_err", {31'd0, rsp_err_a}, 32'd0);
    chk("wr_cs_off", {31'd0, cs_a}, 32'd0);
    chk("wr_addr_off", addr_a, 32'h0);
    tick;
    chk("wr_rsp_off", {31'd0, rsp_valid_a}, 32'd0);
    chk("wr_ready2", {31'd0, cmd_ready_a}, 32'd1);

    // read 0x100 back
    cmd(1'b0, 32'h100, 32'h0);
    tick;
    cmd_valid = 1'b0;
    chk("rd_rd", {31'd0, rd_a}, 32'd1);
    chk("rd_wr", {31'd0, wr_a}, 32'd0);
    chk("rd_addr", addr_a, 32'h100);
    chk("rd_dout", dout_a, 32'h0);
    tick;
    chk("rd_rsp", {31'd0, rsp_valid_a}, 32'd1);
    chk("rd_data", rsp_rdata_a, 32'hDEADBEEF);
    chk("rd_err", {31'd0, rsp_err_a}, 32'd0);
    chk("rd_rd_off", {31'd0, rd_a}, 32'd0);

    // READ_CYCLES=3 on instance b
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
    chk("b_ready", {31'd0, cmd_ready_b}, 32'd1);
    cmd(1'b0, 32'h200, 32'h0);
    n_rd = 0; rsp_at = 0; rdat = '0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      cmd_valid = 1'b0;
      if (rd_b) n_rd++;
      if (rsp_valid_b && rsp_at == 0) begin
        rsp_at = i;
        rdat   = rsp_rdata_b;
      end
    end
    chk("b_rd_cycles", 32'(n_rd), 32'd3);
    chk("b_rsp_cycle", 32'(rsp_at), 32'd4);
    chk("b_rdata", rdat, 32'h01020304);

    // range: last legal word
    cmd(1'b0, 32'hFFC, 32'h0);
    tick;
    cmd_valid = 1'b0;
    chk("ffc_cs", {31'd0, cs_a}, 32'd1);
    chk("ffc_addr", addr_a, 32'hFFC);
    tick;
    chk("ffc_err", {31'd0, rsp_err_a}, 32'd0);
    chk("ffc_rsp", {31'd0, rsp_valid_a}, 32'd1);
    tick;
    // range: one past
    cmd(1'b0, 32'hFFD, 32'h0);
    tick;
    cmd_valid = 1'b0;
    chk("ffd_rsp", {31'd0, rsp_valid_a}, 32'd1);
    chk("ffd_err", {31'd0, rsp_err_a}, 32'd1);
    chk("ffd_data", rsp_rdata_a, 32'h0);
    chk("ffd_cs", {31'd0, cs_a}, 32'd0);
    tick;
    chk("ffd_ready", {31'd0, cmd_ready_a}, 32'd1);
    // range: wrapping write
    cmd(1'b1, 32'hFFFFFFFE, 32'h12345678);
    tick;
    cmd_valid = 1'b0;
    chk("wrap_rsp", {31'd0, rsp_valid_a}, 32'd1);
    chk("wrap_err", {31'd0, rsp_err_a}, 32'd1);
    chk("wrap_cs", {31'd0, cs_a}, 32'd0);
    chk("wrap_dout", dout_a, 32'h0);
    tick;

    // interrupt, intr drops
    intr = 1'b1;
    tick;
    chk("int_pend", {31'd0, int_pend_a}, 32'd1);
    int_service = 1'b1;
    tick;
    int_service = 1'b0;
    chk("ack_on", {31'd0, int_ack_a}, 32'd1);
    chk("ack_ready", {31'd0, cmd_ready_a}, 32'd0);
    tick;
    chk("ack_hold", {31'd0, int_ack_a}, 32'd1);
    intr = 1'b0;
    tick;
    chk("ack_off", {31'd0, int_ack_a}, 32'd0);
    tick;
    chk("ack_ready2", {31'd0, cmd_ready_a}, 32'd1);

    // interrupt, intr stuck: timeout
    intr = 1'b1;
    int_service = 1'b1;
    tick;
    int_service = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      if (int_ack_a) n_ack++;
      tick;
    end
    chk("ack_timeout", 32'(n_ack), 32'd8);
    intr = 1'b0;
    tick;

    // collision: service during read
    cmd(1'b0, 32'h100, 32'h0);
    tick;
    cmd_valid = 1'b0;
    int_service = 1'b1;
    tick;
    int_service = 1'b0;
    chk("col_rsp", {31'd0, rsp_valid_a}, 32'd1);
    chk("col_data", rsp_rdata_a, 32'hDEADBEEF);
    chk("col_ack0", {31'd0, int_ack_a}, 32'd0);
    cmd(1'b0, 32'h100, 32'h0);
    tick;
    chk("col_idle_rdy", {31'd0, cmd_ready_a}, 32'd0);
    chk("col_idle_ack", {31'd0, int_ack_a}, 32'd0);
    tick;
    chk("col_ack", {31'd0, int_ack_a}, 32'd1);
    chk("col_ack_rdy", {31'd0, cmd_ready_a}, 32'd0);
    chk("col_ack_cs", {31'd0, cs_a}, 32'd0);
    tick;
    cmd_valid = 1'b0;
    chk("col_ack_off", {31'd0, int_ack_a}, 32'd0);
    chk("col_ready", {31'd0, cmd_ready_a}, 32'd1);
    tick;

    // reset during a read
    cmd(1'b0, 32'h100, 32'h0);
    tick;
    cmd_valid = 1'b0;
    chk("mr_rd", {31'd0, rd_a}, 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mr_cs", {31'd0, cs_a}, 32'd0);
    chk("mr_rd_off", {31'd0, rd_a}, 32'd0);
    n_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid_a) n_rsp++;
      tick;
    end
    chk("mr_no_rsp", 32'(n_rsp), 32'd0);
    chk("mr_ready", {31'd0, cmd_ready_a}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
